// File: rtl/systolic_fir_filter.sv
// systolic_fir_filter: fixed-coefficient systolic FIR, one signed sample in and one filtered sample out per clock.
// Ports: clk (rising edge), rst (async active-high), din [DIN_W] signed sample, dout [DOUT_W] signed registered result.
// Optional SYSFIR_SAT_EN: saturate the accumulator to DOUT_W instead of two's-complement wrap.
module systolic_fir_filter #(
  parameter int TAPS = 8,
  parameter int DIN_W = 10,
  parameter int COEF_W = 10,
  parameter int DOUT_W = 20,
  parameter logic [TAPS*COEF_W-1:0] COEFS = {-10'sd3, 10'sd0, 10'sd19, 10'sd32, 10'sd32, 10'sd19, 10'sd0, -10'sd3}
) (
  input  logic clk,
  input  logic rst,
  input  logic signed [DIN_W-1:0] din,
  output logic signed [DOUT_W-1:0] dout
);
  localparam int PW = DIN_W + COEF_W;
  localparam int ACC_W = PW + $clog2(TAPS);
  logic signed [DIN_W-1:0] xr;
  logic signed [DIN_W-1:0] sa [TAPS];
  logic signed [DIN_W-1:0] sb [TAPS-1];
  logic signed [ACC_W-1:0] p [TAPS];
  logic signed [PW-1:0] prod [TAPS];
  logic signed [DOUT_W-1:0] red;
  for (genvar k = 0; k < TAPS; k++) begin : g_mul
    assign prod[k] = sa[k] * $signed(COEFS[k*COEF_W +: COEF_W]);
  end
`ifdef SYSFIR_SAT_EN
  logic signed [ACC_W-1:0] acc;
  logic hi, lo;
  assign acc = p[TAPS-1];
  assign hi = ~acc[ACC_W-1] & (|acc[ACC_W-2:DOUT_W-1]);
  assign lo = acc[ACC_W-1] & ~(&acc[ACC_W-2:DOUT_W-1]);
  assign red = hi ? {1'b0, {(DOUT_W-1){1'b1}}} : lo ? {1'b1, {(DOUT_W-1){1'b0}}} : acc[DOUT_W-1:0];
`else
  assign red = DOUT_W'(p[TAPS-1]);
`endif
  // Each cell multiplies its first sample register; the second one only delays the sample for the next cell,
  // so samples move at half the speed of partial sums and line up with the taps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      xr <= '0;
      sa <= '{default: '0};
      sb <= '{default: '0};
      p <= '{default: '0};
      dout <= '0;
    end else begin
      xr <= din;
      sa[0] <= xr;
      p[0] <= {{(ACC_W-PW){prod[0][PW-1]}}, prod[0]};
      for (int k = 1; k < TAPS; k++) begin
        sa[k] <= sb[k-1];
        p[k] <= p[k-1] + {{(ACC_W-PW){prod[k][PW-1]}}, prod[k]};
      end
      for (int k = 0; k < TAPS-1; k++) sb[k] <= sa[k];
      dout <= red;
    end
  end
endmodule

// File: tb/tb_systolic_fir_filter.sv
// tb_systolic_fir_filter: vector table, corner sequences and random stream against a convolution model.
module tb_systolic_fir_filter;
  localparam int TAPS = 8;
  localparam int LAT = TAPS + 2;
  typedef struct {int d; int e;} vec_t;
  int h [TAPS] = '{-3, 0, 19, 32, 32, 19, 0, -3};
  int hist [LAT+TAPS];
  int total = 0;
  int bad = 0;
  logic clk = 0;
  logic rst = 1;
  logic signed [9:0] din = '0;
  logic signed [19:0] dout, dout2;
  vec_t tv [24];
  always #5 clk = ~clk;
  systolic_fir_filter dut (.clk(clk), .rst(rst), .din(din), .dout(dout));
  systolic_fir_filter #(.COEFS({8{10'sd511}})) ovf (.clk(clk), .rst(rst), .din(din), .dout(dout2));
  function automatic int red(input longint v);
`ifdef SYSFIR_SAT_EN
    return v > 524287 ? 524287 : v < -524288 ? -524288 : int'(v);
`else
    longint t = v & 64'hFFFFF;
    return int'(t >= 524288 ? t - 1048576 : t);
`endif
  endfunction
  function automatic int model_y();
    longint s = 0;
    for (int k = 0; k < TAPS; k++) s += longint'(h[k]) * hist[LAT+k];
    return red(s);
  endfunction
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
    end
  endtask
  task automatic drive(input int v);
    @(negedge clk) din = 10'(v);
    @(posedge clk);
    for (int k = LAT+TAPS-1; k > 0; k--) hist[k] = hist[k-1];
    hist[0] = v;
    #1;
  endtask
  initial begin
    logic signed [9:0] r;
    for (int k = 0; k < LAT+TAPS; k++) hist[k] = 0;
    for (int i = 0; i < 24; i++) begin
      tv[i].d = (i == 0) ? 1 : 0;
      tv[i].e = 0;
    end
    tv[10].e = -3; tv[11].e = 0; tv[12].e = 19; tv[13].e = 32;
    tv[14].e = 32; tv[15].e = 19; tv[16].e = 0; tv[17].e = -3;
    repeat (3) @(posedge clk);
    #1;
    check("reset", int'(dout), 0);
    check("reset_ovf", int'(dout2), 0);
    @(negedge clk) rst = 0;
    for (int i = 0; i < 24; i++) begin
      drive(tv[i].d);
      check("impulse", int'(dout), tv[i].e);
    end
    for (int i = 0; i < 20; i++) begin
      drive(511);
      check("step_pos_model", int'(dout), model_y());
      if (i >= LAT+TAPS-1) check("step_pos", int'(dout), 49056);
    end
    for (int i = 0; i < 20; i++) begin
      drive(-512);
      check("step_neg_model", int'(dout), model_y());
      if (i >= LAT+TAPS-1) begin
        check("step_neg", int'(dout), -49152);
        check("overflow", int'(dout2), red(-64'sd2093056));
      end
    end
    for (int i = 0; i < 5; i++) drive(511);
    #2 rst = 1;
    #1 check("rst_async", int'(dout), 0);
    for (int k = 0; k < LAT+TAPS; k++) hist[k] = 0;
    @(posedge clk);
    #1 check("rst_held", int'(dout), 0);
    @(negedge clk) begin rst = 0; din = '0; end
    for (int i = 0; i < 20; i++) begin
      drive(0);
      check("rst_after", int'(dout), 0);
    end
    for (int i = 0; i < 1000; i++) begin
      r = 10'($urandom);
      drive(int'(r));
      check("random", int'(dout), model_y());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
